// File: rtl/router_feeder.sv
// Packet feeder: stamps legal packets with a sequence number, queues them in a
// 4-deep FIFO and issues one per cycle to the downstream router when it is ready.
module router_feeder (
    input  logic        clk,
    input  logic        rst,
    input  logic [42:0] pkt_in,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    input  logic        router_ready,
    output logic [42:0] data_out,
    output logic        data_valid,
    output logic [2:0]  fifo_level,
    output logic [7:0]  drop_count,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2
    } state_t;

    logic [42:0] mem [0:3];
    logic [1:0]  wr_ptr_reg;
    logic [1:0]  rd_ptr_reg;
    logic [2:0]  level_reg;
    logic [2:0]  level_next;
    logic [7:0]  seq_reg;
    logic [7:0]  drop_reg;
    logic [42:0] data_reg;
    logic        valid_reg;
    state_t      state_reg;
    state_t      state_next;

    logic        handshake;
    logic        legal;
    logic        push;
    logic        drop;
    logic        pop;
    logic [42:0] stamped;

    assign pkt_ready  = (level_reg < 3'd4);
    assign handshake  = pkt_valid && pkt_ready;
    assign legal      = (pkt_in[42:40] <= 3'd4);
    assign push       = handshake && legal;
    assign drop       = handshake && !legal;
    // Pop only looks at the pre-edge level, so a packet pushed into an empty queue waits one edge.
    assign pop        = router_ready && (level_reg != 3'd0);

    assign data_out   = data_reg;
    assign data_valid = valid_reg;
    assign fifo_level = level_reg;
    assign drop_count = drop_reg;
    assign state      = state_reg;

    always_comb begin
        stamped      = pkt_in;
        stamped[7:0] = seq_reg;
    end

    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + 3'd1;
            2'b01:   level_next = level_reg - 3'd1;
            default: level_next = level_reg;
        endcase
    end

    always_comb begin
        state_next = IDLE;
        if (level_next != 3'd0) begin
            state_next = router_ready ? ACTIVE : STALL;
        end
    end

    // Storage carries no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= stamped;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= 2'd0;
            rd_ptr_reg <= 2'd0;
            level_reg  <= 3'd0;
            seq_reg    <= 8'd1;
            drop_reg   <= 8'd0;
            data_reg   <= 43'd0;
            valid_reg  <= 1'b0;
            state_reg  <= IDLE;
        end else begin
            level_reg <= level_next;
            state_reg <= state_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 2'd1;
                seq_reg    <= (seq_reg == 8'd255) ? 8'd1 : seq_reg + 8'd1;
            end
            if (drop && (drop_reg != 8'd255)) begin
                drop_reg <= drop_reg + 8'd1;
            end
            if (pop) begin
                data_reg   <= mem[rd_ptr_reg];
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
                valid_reg  <= 1'b1;
            end else begin
                valid_reg  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_router_feeder.sv
// Directed bench for router_feeder: single packet, illegal drop, backpressure,
// sequence wrap, asynchronous reset mid-stream and steady push/pop.
module tb_router_feeder;

    logic        clk;
    logic        rst;
    logic [42:0] pkt_in;
    logic        pkt_valid;
    logic        pkt_ready;
    logic        router_ready;
    logic [42:0] data_out;
    logic        data_valid;
    logic [2:0]  fifo_level;
    logic [7:0]  drop_count;
    logic [1:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    router_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .pkt_in       (pkt_in),
        .pkt_valid    (pkt_valid),
        .pkt_ready    (pkt_ready),
        .router_ready (router_ready),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .fifo_level   (fifo_level),
        .drop_count   (drop_count),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    function automatic logic [42:0] mk(input logic [2:0] ch, input logic [7:0] s1, input logic [7:0] s0,
                                       input logic [7:0] d1, input logic [7:0] d0, input logic [7:0] sq);
        return {ch, s1, s0, d1, d0, sq};
    endfunction

    // Advance one cycle; inputs are driven and outputs sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        pkt_valid = 1'b0;
        router_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_seq;
        int         issued;
        logic [7:0] last_seq;

        rst = 1'b0;
        pkt_in = '0;
        pkt_valid = 1'b0;
        router_ready = 1'b0;
        #2;
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_valid", 64'(data_valid), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        check("rst_state", 64'(state), 64'd0);
        check("rst_pkt_ready", 64'(pkt_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;

        // Single packet
        router_ready = 1'b1;
        pkt_in = mk(3'd2, 8'd170, 8'd153, 8'd26, 8'd104, 8'hFF);
        pkt_valid = 1'b1;
        step();
        pkt_valid = 1'b0;
        check("single_level_after_push", 64'(fifo_level), 64'd1);
        check("single_no_bypass", 64'(data_valid), 64'd0);
        check("single_state_active", 64'(state), 64'd1);
        step();
        check("single_data_out", 64'(data_out), 64'(mk(3'd2, 8'd170, 8'd153, 8'd26, 8'd104, 8'd1)));
        check("single_valid", 64'(data_valid), 64'd1);
        check("single_level_zero", 64'(fifo_level), 64'd0);
        check("single_state_idle", 64'(state), 64'd0);
        step();
        check("single_valid_pulse", 64'(data_valid), 64'd0);
        check("single_data_hold", 64'(data_out), 64'(mk(3'd2, 8'd170, 8'd153, 8'd26, 8'd104, 8'd1)));

        // Illegal channel code is dropped without consuming a sequence number
        do_reset();
        router_ready = 1'b1;
        pkt_in = mk(3'd6, 8'd83, 8'd168, 8'd1, 8'd2, 8'h00);
        pkt_valid = 1'b1;
        step();
        check("illegal_drop_count", 64'(drop_count), 64'd1);
        check("illegal_level", 64'(fifo_level), 64'd0);
        pkt_in = mk(3'd1, 8'd83, 8'd168, 8'd3, 8'd4, 8'h00);
        step();
        pkt_valid = 1'b0;
        check("illegal_second_queued", 64'(fifo_level), 64'd1);
        check("illegal_no_issue", 64'(data_valid), 64'd0);
        step();
        check("illegal_second_issued", 64'(data_out), 64'(mk(3'd1, 8'd83, 8'd168, 8'd3, 8'd4, 8'd1)));
        check("illegal_second_valid", 64'(data_valid), 64'd1);
        check("illegal_drop_hold", 64'(drop_count), 64'd1);

        // Backpressure: fill, refuse the fifth, then drain in order
        do_reset();
        router_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pkt_in = mk(3'(i % 5), 8'(i), 8'h10, 8'h20, 8'h30, 8'h00);
            pkt_valid = 1'b1;
            step();
        end
        pkt_valid = 1'b0;
        check("bp_level_full", 64'(fifo_level), 64'd4);
        check("bp_pkt_ready_low", 64'(pkt_ready), 64'd0);
        check("bp_state_stall", 64'(state), 64'd2);
        check("bp_no_drop", 64'(drop_count), 64'd0);
        router_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("bp_valid_%0d", i), 64'(data_valid), 64'd1);
            check($sformatf("bp_pkt_%0d", i), 64'(data_out),
                  64'(mk(3'(i % 5), 8'(i), 8'h10, 8'h20, 8'h30, 8'(i + 1))));
            if (i == 0) check("bp_ready_after_pop", 64'(pkt_ready), 64'd1);
        end
        check("bp_drained_level", 64'(fifo_level), 64'd0);
        check("bp_drained_state", 64'(state), 64'd0);
        step();
        check("bp_fifth_not_issued", 64'(data_valid), 64'd0);

        // Sequence wrap across 256 legal packets
        do_reset();
        router_ready = 1'b1;
        exp_seq = 8'd1;
        issued = 0;
        last_seq = 8'd0;
        for (int i = 0; i < 260; i++) begin
            pkt_valid = (i < 256);
            pkt_in = mk(3'(i % 5), 8'(i), 8'(i >> 8), 8'h5A, 8'hA5, 8'h00);
            step();
            if (data_valid) begin
                check($sformatf("wrap_seq_%0d", issued), 64'(data_out[7:0]), 64'(exp_seq));
                last_seq = data_out[7:0];
                exp_seq = (exp_seq == 8'd255) ? 8'd1 : exp_seq + 8'd1;
                issued++;
            end
        end
        pkt_valid = 1'b0;
        check("wrap_issued_count", 64'(issued), 64'd256);
        check("wrap_last_seq", 64'(last_seq), 64'd1);

        // Asynchronous reset while packets are queued
        do_reset();
        router_ready = 1'b1;
        pkt_in = mk(3'd7, 8'd1, 8'd2, 8'd3, 8'd4, 8'h00);
        pkt_valid = 1'b1;
        step();
        pkt_in = mk(3'd3, 8'd9, 8'd8, 8'd7, 8'd6, 8'h00);
        step();
        pkt_valid = 1'b0;
        step();
        check("mid_pre_issue", 64'(data_out), 64'(mk(3'd3, 8'd9, 8'd8, 8'd7, 8'd6, 8'd1)));
        router_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pkt_in = mk(3'd0, 8'(i), 8'd0, 8'd0, 8'd0, 8'h00);
            pkt_valid = 1'b1;
            step();
        end
        pkt_valid = 1'b0;
        check("mid_queued", 64'(fifo_level), 64'd3);
        #2;
        rst = 1'b0;
        #1;
        check("mid_async_data_out", 64'(data_out), 64'd0);
        check("mid_async_level", 64'(fifo_level), 64'd0);
        check("mid_async_drop", 64'(drop_count), 64'd0);
        check("mid_async_state", 64'(state), 64'd0);
        #1;
        rst = 1'b1;
        @(negedge clk);
        router_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("mid_no_issue_%0d", i), 64'(data_valid), 64'd0);
        end
        pkt_in = mk(3'd4, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h77);
        pkt_valid = 1'b1;
        step();
        pkt_valid = 1'b0;
        step();
        check("mid_new_valid", 64'(data_valid), 64'd1);
        check("mid_new_pkt", 64'(data_out), 64'(mk(3'd4, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'd1)));

        // Steady concurrent push and pop at level 2
        do_reset();
        router_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pkt_in = mk(3'd1, 8'(i), 8'h00, 8'h00, 8'h00, 8'h00);
            pkt_valid = 1'b1;
            step();
        end
        router_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pkt_in = mk(3'd1, 8'(i + 2), 8'h00, 8'h00, 8'h00, 8'h00);
            pkt_valid = 1'b1;
            step();
            check($sformatf("cc_level_%0d", i), 64'(fifo_level), 64'd2);
            check($sformatf("cc_state_%0d", i), 64'(state), 64'd1);
            check($sformatf("cc_valid_%0d", i), 64'(data_valid), 64'd1);
            check($sformatf("cc_seq_%0d", i), 64'(data_out[7:0]), 64'(i + 1));
        end
        pkt_valid = 1'b0;
        step();
        check("cc_drain_seq_a", 64'(data_out[7:0]), 64'd11);
        step();
        check("cc_drain_seq_b", 64'(data_out[7:0]), 64'd12);
        check("cc_drain_level", 64'(fifo_level), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
